ysyx_23060025_axi_rd_arbiter: RTL
=================================

// Module: ysyx_23060025_axi_rd_arbiter
// PURPOSE
//  Two-master AXI read-channel arbiter placed between the fetch unit (IFU) and the load/store unit (LSU),
//  feeding the single read master port of ysyx_23060025_xbar. Grants one read transaction at a time and
//  routes its AR/R handshakes. Write channels are LSU-only and do not pass through this block.
// PARAMETERS
//  ADDR_LEN   32      address width
//  DATA_LEN   32      read data width
//  AR_LEN     8'd0    burst length driven on m_ar_len_o (beats-1)
//  AR_SIZE    3'd2    beat size driven on m_ar_size_o (2 = 4 bytes)
// PORTS
//  clock                          in   1         single clock, rising edge
//  rstn                           in   1         asynchronous active-low reset
//  ifu_ar_addr_i / lsu_ar_addr_i  in   ADDR_LEN  requester read address, held while valid
//  ifu_ar_valid_i / lsu_ar_valid_i in  1         requester AR valid
//  ifu_ar_ready_o / lsu_ar_ready_o out 1         AR accepted (granted requester only)
//  ifu_r_data_o / lsu_r_data_o    out  DATA_LEN  read data (both driven from m_r_data_i)
//  ifu_r_valid_o / lsu_r_valid_o  out  1         read data valid (granted requester only)
//  ifu_r_last_o / lsu_r_last_o    out  1         last beat (granted requester only)
//  ifu_r_ready_i / lsu_r_ready_i  in   1         requester accepts read data
//  m_ar_addr_o                    out  ADDR_LEN  to xbar axi_ctl_addr_r_addr_i
//  m_ar_valid_o / m_ar_ready_i    out/in 1       to/from xbar AR handshake
//  m_ar_len_o / m_ar_size_o       out  8 / 3     constant AR_LEN / AR_SIZE
//  m_r_data_i                     in   DATA_LEN  from xbar
//  m_r_valid_i / m_r_last_i       in   1         from xbar
//  m_r_ready_o                    out  1         to xbar
//  grant_o                        out  2         one-hot {lsu,ifu} owner; 2'b00 when idle
// BEHAVIOUR
//  - FSM states: IDLE, ADDR, DATA. Registers: state, grant[1:0], last_grant.
//  - Reset (rstn low, async): state=IDLE, grant=00, last_grant=LSU; all valid/ready/last outputs 0,
//    m_ar_addr_o=0. Reset mid-transaction discards it; xbar/slave share rstn and abort too.
//  - IDLE: if any *_ar_valid_i, latch winner into grant, go ADDR next edge (1-cycle grant latency);
//    else stay. No request is visible downstream in IDLE (m_ar_valid_o=0).
//  - ADDR: m_ar_addr_o/m_ar_valid_o = granted requester's addr/valid; granted *_ar_ready_o = m_ar_ready_i.
//    On m_ar_valid_o && m_ar_ready_i -> DATA. Requester must hold valid (AXI rule); if it drops, stay ADDR.
//  - DATA: granted *_r_valid_o/_r_last_o = m_r_valid_i/m_r_last_i; m_r_ready_o = granted *_r_ready_i.
//    On m_r_valid_i && m_r_ready_o && m_r_last_i -> IDLE, grant=00, last_grant=owner.
//    Non-last beats stay DATA (AR_LEN>0 bursts).
//  - Ungranted requester: ar_ready=0, r_valid=0, r_last=0 in every state. m_ar_valid_o=0 outside ADDR;
//    m_r_ready_o=0 outside DATA.
//  - One bubble cycle in IDLE between back-to-back transactions; min transaction = 3 cycles + slave latency.
//  - grant_o mirrors grant register; changes only on clock edges.
//  - New requests arriving in ADDR/DATA wait; never preempt. Requester valid held across arbitration loss.
// CONFIGURATION
//  ARB_RR_EN defined:   simultaneous requests in IDLE -> owner != last_grant (round robin); first tie after
//                       reset goes to IFU.
//  ARB_RR_EN undefined: fixed priority, LSU always wins ties; last_grant still updated but unused.
//  Single request: granted immediately in both modes.
// TESTING
//  1 IFU-only: ifu addr 0x8000_0000, slave data 0x0000_0413 after 2 cycles -> grant_o=01 at cycle 1,
//    m_ar_valid_o cycle 1, ifu_r_valid_o with data 0x413, IDLE after last; lsu outputs stay 0.
//  2 Tie, ARB_RR_EN off: both valid in IDLE x3 transactions -> LSU granted all three; IFU waits, valid held.
//  3 Tie, ARB_RR_EN on: both valid continuously -> grants IFU, LSU, IFU, LSU (grant_o 01,10,01,10).
//  4 Backpressure: m_ar_ready_i low 5 cycles, then lsu_r_ready_i low 3 cycles after r_valid -> FSM holds
//    ADDR/DATA, m_r_ready_o low while lsu_r_ready_i low, single handshake each, no duplicate beat.
//  5 Burst AR_LEN=3: 4 beats, last on 4th -> stays DATA through beats 1-3, IDLE after beat 4.
//  6 Async reset asserted mid-DATA (between clock edges) -> all outputs 0 immediately, grant_o=00,
//    next request after release arbitrated normally.

Source files
------------

// File: rtl/ysyx_23060025_axi_rd_arbiter.sv
// Two-master (IFU/LSU) AXI read arbiter in front of the xbar read port.
// Define ARB_RR_EN for round-robin ties; otherwise LSU has fixed priority.
module ysyx_23060025_axi_rd_arbiter #(
    parameter int unsigned ADDR_LEN = 32,
    parameter int unsigned DATA_LEN = 32,
    parameter logic [7:0]  AR_LEN   = 8'd0,
    parameter logic [2:0]  AR_SIZE  = 3'd2
) (
    input  logic                clock,
    input  logic                rstn,

    input  logic [ADDR_LEN-1:0] ifu_ar_addr_i,
    input  logic                ifu_ar_valid_i,
    output logic                ifu_ar_ready_o,
    output logic [DATA_LEN-1:0] ifu_r_data_o,
    output logic                ifu_r_valid_o,
    output logic                ifu_r_last_o,
    input  logic                ifu_r_ready_i,

    input  logic [ADDR_LEN-1:0] lsu_ar_addr_i,
    input  logic                lsu_ar_valid_i,
    output logic                lsu_ar_ready_o,
    output logic [DATA_LEN-1:0] lsu_r_data_o,
    output logic                lsu_r_valid_o,
    output logic                lsu_r_last_o,
    input  logic                lsu_r_ready_i,

    output logic [ADDR_LEN-1:0] m_ar_addr_o,
    output logic                m_ar_valid_o,
    input  logic                m_ar_ready_i,
    output logic [7:0]          m_ar_len_o,
    output logic [2:0]          m_ar_size_o,
    input  logic [DATA_LEN-1:0] m_r_data_i,
    input  logic                m_r_valid_i,
    input  logic                m_r_last_i,
    output logic                m_r_ready_o,

    output logic [1:0]          grant_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t     state;
    state_t     state_d;
    logic [1:0] grant;
    logic [1:0] grant_d;
    logic       last_grant;
    logic       last_grant_d;
    logic       pick_lsu;
    logic       ar_fire;
    logic       r_done;

    // last_grant: 1 = LSU owned the previous transaction
`ifdef ARB_RR_EN
    always_comb begin
        if (ifu_ar_valid_i && lsu_ar_valid_i) begin
            pick_lsu = ~last_grant;
        end else begin
            pick_lsu = lsu_ar_valid_i;
        end
    end
`else
    always_comb begin
        pick_lsu = lsu_ar_valid_i;
    end
`endif

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            grant      <= 2'b00;
            last_grant <= 1'b1;
        end else begin
            state      <= state_d;
            grant      <= grant_d;
            last_grant <= last_grant_d;
        end
    end

    always_comb begin
        state_d        = state;
        grant_d        = grant;
        last_grant_d   = last_grant;
        m_ar_addr_o    = '0;
        m_ar_valid_o   = 1'b0;
        m_r_ready_o    = 1'b0;
        ifu_ar_ready_o = 1'b0;
        lsu_ar_ready_o = 1'b0;
        ifu_r_valid_o  = 1'b0;
        lsu_r_valid_o  = 1'b0;
        ifu_r_last_o   = 1'b0;
        lsu_r_last_o   = 1'b0;
        ar_fire        = 1'b0;
        r_done         = 1'b0;

        unique case (state)
            IDLE: begin
                if (ifu_ar_valid_i || lsu_ar_valid_i) begin
                    state_d = ADDR;
                    grant_d = pick_lsu ? 2'b10 : 2'b01;
                end
            end

            ADDR: begin
                unique case (1'b1)
                    grant[1]: begin
                        m_ar_addr_o    = lsu_ar_addr_i;
                        m_ar_valid_o   = lsu_ar_valid_i;
                        lsu_ar_ready_o = m_ar_ready_i;
                    end
                    grant[0]: begin
                        m_ar_addr_o    = ifu_ar_addr_i;
                        m_ar_valid_o   = ifu_ar_valid_i;
                        ifu_ar_ready_o = m_ar_ready_i;
                    end
                    default: ;
                endcase
                ar_fire = m_ar_valid_o && m_ar_ready_i;
                if (ar_fire) begin
                    state_d = DATA;
                end
            end

            DATA: begin
                unique case (1'b1)
                    grant[1]: begin
                        lsu_r_valid_o = m_r_valid_i;
                        lsu_r_last_o  = m_r_last_i;
                        m_r_ready_o   = lsu_r_ready_i;
                    end
                    grant[0]: begin
                        ifu_r_valid_o = m_r_valid_i;
                        ifu_r_last_o  = m_r_last_i;
                        m_r_ready_o   = ifu_r_ready_i;
                    end
                    default: ;
                endcase
                // non-last beats keep the owner until the burst ends
                r_done = m_r_valid_i && m_r_ready_o && m_r_last_i;
                if (r_done) begin
                    state_d      = IDLE;
                    grant_d      = 2'b00;
                    last_grant_d = grant[1];
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    assign ifu_r_data_o = m_r_data_i;
    assign lsu_r_data_o = m_r_data_i;
    assign m_ar_len_o   = AR_LEN;
    assign m_ar_size_o  = AR_SIZE;
    assign grant_o      = grant;

endmodule
